xnor_conv_pipe: RTL and testbench
=================================

# xnor_conv_pipe

Three-stage pipelined binary (XNOR/popcount) 3x3 convolution engine that consumes the column stream produced by the input-row datapath: one 3-bit column (one bit from each of three buffered input rows) per accepted cycle. It keeps a sliding 3-column window, matches it against the 9-bit kernel, and emits one output bit per complete window, tagged with its output column index. Its output feeds the row-packing/write stage that builds 16-bit output words.

## Interface
Parameters:
- NCOL_MAX, 16, maximum input columns per row; output index width 4 bits.
- THRESH, 5, minimum XNOR match count (of 9) for out_bit = 1, meaning the convolution sum is non-negative.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- wt_load  in  1  load the kernel from wt_in.
- wt_in  in  16  kernel word; bits [8:0] are used, and bit 3*r+k is kernel row r, column k (k=0 is the oldest column); bits [15:9] are ignored.
- row_start  in  1  a new input row begins.
- col_valid  in  1  col_in is valid this cycle.
- col_in  in  3  column bits; bit r is input row r.
- row_last  in  1  qualifies col_valid: this is the final column of the row.
- out_valid  out  1  out_bit and out_idx are valid.
- out_bit  out  1  1 when the match count is at least THRESH.
- out_idx  out  4  output column index, 0..NCOL_MAX-3.
- out_last  out  1  with out_valid: last output of the row.
- busy  out  1  any pipeline stage holds valid data.
- ovf  out  1  sticky: a column beyond NCOL_MAX was received in a row.

## Operation
- Kernel register: 9 bits; on wt_load it takes wt_in[8:0].
- Column counter: 5 bits.
  - row_start clears it. If row_start and col_valid are high in the same cycle, that column is column 0.
  - Each accepted column increments the counter, saturating at NCOL_MAX.
- Stage 0 (window): on an accepted column, shift the window w2<=w1, w1<=w0, w0<=col_in.
  - s0_valid = 1 when the accepted column's index is 2 or more.
  - s0_idx = index - 2.
  - s0_last = row_last.
- Stage 1 (match plus full-add): m[r][k] = XNOR(window bit, kernel bit 3*r+k), combinational from the window and the current kernel register.
  - For each kernel column k, full-add m[0..2][k], registering sum bit ones[k] and carry bit twos[k].
  - idx, last and valid are passed along.
- Stage 2 (reduce): total = popcount(ones) + 2*popcount(twos), range 0..9, computed 4 bits wide.
  - out_bit = (total >= THRESH).
  - out_idx, out_last and out_valid are registered.
- Ignored columns: a column whose pre-increment index equals NCOL_MAX is ignored (no shift, no output) and sets ovf. ovf clears only on reset.
- Row boundary: row_start does not flush stages 1 and 2. In-flight results complete unchanged; only the fill count restarts, so the new row's first two columns never produce output.
- busy = s0_valid | s1_valid | out_valid.
- Kernel timing: a wt_load while busy is legal. The new kernel applies to stage-1 computations from the next cycle onward; windows already in stage 2 keep their old result.

## Timing
- Latency: a column sampled at edge E completes a window whose result appears at edge E+2. With col_valid high in cycle n, out_valid is high in cycle n+3.
- Throughput is one column per cycle. There is no back-pressure, so the consumer must accept every out_valid.
- out_valid pulses are single-cycle per window. They are gapless when columns are gapless, and gaps in col_valid propagate unchanged.
- Reset values: every output, pipeline register, window, kernel and counter is 0. out_valid=0, out_bit=0, out_idx=0, out_last=0, busy=0, ovf=0.
- Reset mid-operation: all in-flight results are discarded immediately and no out_valid is produced for them.
- out_last is high only together with out_valid. A row of fewer than 3 columns never asserts out_last.

## Test plan
- Kernel wt_in=16'h01FF, one row of 5 columns all 3'b111 -> out_valid in 3 consecutive cycles, each with out_bit=1, out_idx 0,1,2, and out_last on idx 2. The first output appears 3 cycles after the third column.
- Same kernel, columns 3'b000 -> all out_bit=0 (total=0). Kernel 16'h0000 with zero data -> out_bit=1 (total=9).
- Threshold edge: windows with exactly 5 matches -> out_bit=1; exactly 4 matches -> out_bit=0. Cover at least 3 distinct bit placements across kernel columns.
- Row restart: row_start coincident with the 2nd column of a new row while the prior row's last result is still in flight -> the prior result emerges intact with out_last=1, and the new row produces no output until its 3rd column.
- Overflow: 17 columns in one row -> outputs idx 0..13 only, ovf=1 after the 17th column. ovf stays 1 across the next row_start and clears only on reset_b.
- Reset while busy=1 (stream running) -> all outputs are 0 asynchronously, and no stale out_valid appears after reset release.

Source files
------------

// File: rtl/xnor_conv_pipe.sv
// xnor_conv_pipe
// Three-stage binary 3x3 convolution engine. Consumes one 3-bit column per
// accepted cycle, keeps a sliding 3-column window, XNOR-matches it against a
// 9-bit kernel and emits one thresholded bit per complete window, tagged with
// its output column index.
//
// Stream semantics: col_valid qualifies col_in, row_last and the column count
// for exactly one cycle. There is no ready signal; every valid column is
// consumed in the cycle it is presented. out_valid is a single-cycle pulse per
// window and out_bit/out_idx/out_last are meaningful only with it. There is no
// back-pressure, so the consumer must take every out_valid pulse.

module xnor_conv_pipe #(
    parameter int NCOL_MAX = 16,
    parameter int THRESH   = 5
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        wt_load,
    input  logic [15:0] wt_in,
    input  logic        row_start,
    input  logic        col_valid,
    input  logic [2:0]  col_in,
    input  logic        row_last,
    output logic        out_valid,
    output logic        out_bit,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        ovf
);

    localparam logic [4:0] COL_LIMIT = 5'(NCOL_MAX);
    localparam logic [3:0] THRESH_L  = 4'(THRESH);

    // Column bookkeeping and kernel
    logic [4:0] col_cnt_q, col_cnt_d;
    logic       ovf_q, ovf_d;
    logic [8:0] kern_q, kern_d;

    // Stage 0: sliding window (w0 newest, w2 oldest) and window tag
    logic [2:0] w0_q, w1_q, w2_q;
    logic       s0_valid_q;
    logic       s0_last_q;
    logic [3:0] s0_idx_q;

    // Stage 1: per-kernel-column full-adder results
    logic       s1_valid_q;
    logic       s1_last_q;
    logic [3:0] s1_idx_q;
    logic [2:0] s1_ones_q;
    logic [2:0] s1_twos_q;

    // Stage 2: output registers
    logic       out_valid_q;
    logic       out_bit_q;
    logic [3:0] out_idx_q;
    logic       out_last_q;

    // Combinational helpers
    logic [4:0] col_idx;
    logic       col_accept;
    logic       col_drop;
    logic       col_emit;
    logic [3:0] s0_idx_d;
    logic [8:0] win_bits;
    logic [8:0] match;
    logic [2:0] ones_d;
    logic [2:0] twos_d;
    logic [3:0] ones_sum;
    logic [2:0] twos_sum;
    logic [3:0] total;
    logic       out_bit_d;
    logic       unused_wt;

    // Kernel bits 15:9 carry no meaning for a 3x3 kernel.
    assign unused_wt = ^wt_in[15:9];

    // A row_start arriving with a column makes that column index 0.
    assign col_idx    = row_start ? 5'd0 : col_cnt_q;
    assign col_accept = col_valid && (col_idx != COL_LIMIT);
    assign col_drop   = col_valid && (col_idx == COL_LIMIT);
    assign col_emit   = col_accept && (col_idx >= 5'd2);
    assign s0_idx_d   = 4'(col_idx - 5'd2);

    // Next-state for the column counter, sticky overflow flag and kernel
    always_comb begin
        col_cnt_d = col_cnt_q;
        if (col_accept) begin
            // col_idx is below COL_LIMIT here, so the count saturates there.
            col_cnt_d = col_idx + 5'd1;
        end else if (row_start) begin
            col_cnt_d = 5'd0;
        end
        ovf_d  = ovf_q | col_drop;
        kern_d = wt_load ? wt_in[8:0] : kern_q;
    end

    // Column counter, overflow flag and kernel register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            col_cnt_q <= 5'd0;
            ovf_q     <= 1'b0;
            kern_q    <= 9'd0;
        end else begin
            col_cnt_q <= col_cnt_d;
            ovf_q     <= ovf_d;
            kern_q    <= kern_d;
        end
    end

    // Stage 0: shift the window on accepted columns and tag complete windows
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            w0_q       <= 3'd0;
            w1_q       <= 3'd0;
            w2_q       <= 3'd0;
            s0_valid_q <= 1'b0;
            s0_last_q  <= 1'b0;
            s0_idx_q   <= 4'd0;
        end else begin
            if (col_accept) begin
                w2_q <= w1_q;
                w1_q <= w0_q;
                w0_q <= col_in;
            end
            s0_valid_q <= col_emit;
            // last is masked by emit so a short row never flags out_last.
            s0_last_q  <= col_emit & row_last;
            if (col_emit) begin
                s0_idx_q <= s0_idx_d;
            end
        end
    end

    // Window laid out like the kernel: bit 3*r+k is row r of kernel column k,
    // with kernel column 0 being the oldest window column.
    for (genvar r = 0; r < 3; r++) begin : g_win_row
        assign win_bits[3*r+0] = w2_q[r];
        assign win_bits[3*r+1] = w1_q[r];
        assign win_bits[3*r+2] = w0_q[r];
    end

    assign match = ~(win_bits ^ kern_q);

    // Full-add the three row matches of each kernel column
    always_comb begin
        ones_d = 3'd0;
        twos_d = 3'd0;
        for (int k = 0; k < 3; k++) begin
            ones_d[k] = match[k] ^ match[k+3] ^ match[k+6];
            twos_d[k] = (match[k]   & match[k+3]) |
                        (match[k]   & match[k+6]) |
                        (match[k+3] & match[k+6]);
        end
    end

    // Stage 1: register the partial sums against the current kernel
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= 4'd0;
            s1_ones_q  <= 3'd0;
            s1_twos_q  <= 3'd0;
        end else begin
            s1_valid_q <= s0_valid_q;
            s1_last_q  <= s0_last_q;
            if (s0_valid_q) begin
                s1_idx_q  <= s0_idx_q;
                s1_ones_q <= ones_d;
                s1_twos_q <= twos_d;
            end
        end
    end

    // Reduce: total = popcount(ones) + 2*popcount(twos), at most 9.
    assign ones_sum  = 4'(s1_ones_q[0]) + 4'(s1_ones_q[1]) + 4'(s1_ones_q[2]);
    assign twos_sum  = 3'(s1_twos_q[0]) + 3'(s1_twos_q[1]) + 3'(s1_twos_q[2]);
    assign total     = ones_sum + {twos_sum, 1'b0};
    assign out_bit_d = (total >= THRESH_L);

    // Stage 2: register the thresholded result and its tag
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_idx_q   <= 4'd0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_last_q;
            if (s1_valid_q) begin
                out_bit_q <= out_bit_d;
                out_idx_q <= s1_idx_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;
    assign busy      = s0_valid_q | s1_valid_q | out_valid_q;

endmodule

// File: tb/tb_xnor_conv_pipe.sv
// tb_xnor_conv_pipe
// Directed bench for xnor_conv_pipe. Expected outputs are hand-computed and
// queued as {out_bit, out_idx, out_last}; a negedge monitor pops and compares.

module tb_xnor_conv_pipe;

    logic        clk;
    logic        reset_b;
    logic        wt_load;
    logic [15:0] wt_in;
    logic        row_start;
    logic        col_valid;
    logic [2:0]  col_in;
    logic        row_last;
    logic        out_valid;
    logic        out_bit;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        ovf;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [5:0]  exp_q[$];
    logic [5:0]  mon_entry;

    // Threshold vectors (kernel 0): matches = 9 - ones in the window
    logic [2:0]  thr_cols [9] = '{3'b111, 3'b001, 3'b000, 3'b111, 3'b011,
                                  3'b100, 3'b010, 3'b110, 3'b011};
    logic        thr_bits [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Row-mapping vectors (kernel 16'h0007, row 0 all ones)
    logic [2:0]  map_cols [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b100};
    logic        map_bits [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    xnor_conv_pipe dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .wt_load   (wt_load),
        .wt_in     (wt_in),
        .row_start (row_start),
        .col_valid (col_valid),
        .col_in    (col_in),
        .row_last  (row_last),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .ovf       (ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic b, input logic [3:0] idx, input logic last);
        exp_q.push_back({b, idx, last});
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic drive_col(input logic rs, input logic [2:0] c, input logic last);
        row_start = rs;
        col_valid = 1'b1;
        col_in    = c;
        row_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        row_start = 1'b0;
        col_valid = 1'b0;
        col_in    = 3'd0;
        row_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_kernel(input logic [15:0] w);
        wt_load = 1'b1;
        wt_in   = w;
        @(posedge clk);
        #1;
        wt_load = 1'b0;
    endtask

    task automatic drain(input string tag);
        idle(6);
        check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_out_bit"},   32'(out_bit),   32'd0);
        check_val({tag, "_out_idx"},   32'(out_idx),   32'd0);
        check_val({tag, "_out_last"},  32'(out_last),  32'd0);
        check_val({tag, "_busy"},      32'(busy),      32'd0);
        check_val({tag, "_ovf"},       32'(ovf),       32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset_b) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_entry = exp_q.pop_front();
                    check_val("out_word", {26'd0, out_bit, out_idx, out_last}, {26'd0, mon_entry});
                end
            end else begin
                check_val("last_without_valid", 32'(out_last), 32'd0);
            end
        end
    end

    initial begin
        reset_b   = 1'b0;
        wt_load   = 1'b0;
        wt_in     = 16'd0;
        row_start = 1'b0;
        col_valid = 1'b0;
        col_in    = 3'd0;
        row_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #1 reset_b = 1'b1;
        @(posedge clk);
        #1;

        // All-ones kernel, all-ones data: latency and gapless outputs
        load_kernel(16'h01FF);
        push_exp(1'b1, 4'd0, 1'b0);
        push_exp(1'b1, 4'd1, 1'b0);
        push_exp(1'b1, 4'd2, 1'b1);
        drive_col(1'b1, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b0);
        check_val("lat_c3", 32'(out_valid), 32'd0);
        check_val("busy_run", 32'(busy), 32'd1);
        drive_col(1'b0, 3'b111, 1'b0);
        check_val("lat_c4", 32'(out_valid), 32'd0);
        drive_col(1'b0, 3'b111, 1'b1);
        check_val("lat_c5", 32'(out_valid), 32'd1);
        idle(1);
        check_val("gapless_1", 32'(out_valid), 32'd1);
        idle(1);
        check_val("gapless_2", 32'(out_valid), 32'd1);
        idle(1);
        check_val("gap_end", 32'(out_valid), 32'd0);
        drain("ones");

        // Same kernel, zero data: total 0
        push_exp(1'b0, 4'd0, 1'b1);
        drive_col(1'b1, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b1);
        drain("zero_data");

        // Zero kernel, zero data: total 9
        load_kernel(16'h0000);
        push_exp(1'b1, 4'd0, 1'b1);
        drive_col(1'b1, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b1);
        drain("zero_kern");

        // Threshold edge: 5 and 4 matches in several placements
        for (int i = 0; i < 7; i++) push_exp(thr_bits[i], 4'(i), i == 6);
        for (int i = 0; i < 9; i++) drive_col(i == 0, thr_cols[i], i == 8);
        drain("thresh");

        // Kernel column mapping, upper kernel bits ignored
        load_kernel(16'hFE49);
        push_exp(1'b1, 4'd0, 1'b0);
        push_exp(1'b0, 4'd1, 1'b1);
        drive_col(1'b1, 3'b111, 1'b0);
        drive_col(1'b0, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b0);
        drive_col(1'b0, 3'b111, 1'b1);
        drain("col_map");

        // Kernel row mapping
        load_kernel(16'h0007);
        for (int i = 0; i < 4; i++) push_exp(map_bits[i], 4'(i), i == 3);
        for (int i = 0; i < 6; i++) drive_col(i == 0, map_cols[i], i == 5);
        drain("row_map");

        // Kernel swap mid-stream: the window completed alongside wt_load uses the new kernel
        load_kernel(16'h01FF);
        push_exp(1'b1, 4'd0, 1'b0);
        push_exp(1'b0, 4'd1, 1'b0);
        push_exp(1'b0, 4'd2, 1'b1);
        drive_col(1'b1, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b0);
        wt_load = 1'b1;
        wt_in   = 16'h0000;
        drive_col(1'b0, 3'b111, 1'b0);
        wt_load = 1'b0;
        drive_col(1'b0, 3'b111, 1'b1);
        drain("kern_swap");

        // Row restart while the prior row's last result is in flight
        load_kernel(16'h01FF);
        push_exp(1'b0, 4'd0, 1'b1);
        push_exp(1'b1, 4'd0, 1'b1);
        drive_col(1'b1, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b0);
        drive_col(1'b0, 3'b001, 1'b1);
        drive_col(1'b1, 3'b000, 1'b0);
        drive_col(1'b1, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b0);
        drive_col(1'b0, 3'b011, 1'b1);
        drain("restart");

        // Overflow: 17 columns, idx 0..13 only, 17th column ignored
        for (int i = 0; i < 14; i++) push_exp(1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 16; i++) drive_col(i == 0, 3'b111, 1'b0);
        check_val("ovf_at16", 32'(ovf), 32'd0);
        drive_col(1'b0, 3'b000, 1'b1);
        check_val("ovf_at17", 32'(ovf), 32'd1);
        drain("ovf_row");
        push_exp(1'b1, 4'd0, 1'b1);
        drive_col(1'b1, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b0);
        drive_col(1'b0, 3'b111, 1'b1);
        check_val("ovf_sticky_run", 32'(ovf), 32'd1);
        drain("ovf_next");
        check_val("ovf_sticky_idle", 32'(ovf), 32'd1);

        // Reset while the stream is running
        push_exp(1'b1, 4'd0, 1'b0);
        push_exp(1'b1, 4'd1, 1'b0);
        for (int i = 0; i < 6; i++) drive_col(i == 0, 3'b111, 1'b0);
        row_start = 1'b0;
        col_valid = 1'b0;
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 reset_b = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 reset_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_val("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        check_val("post_rst_ovf", 32'(ovf), 32'd0);

        // Kernel returns to zero after reset: zero data gives total 9
        push_exp(1'b1, 4'd0, 1'b1);
        drive_col(1'b1, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b0);
        drive_col(1'b0, 3'b000, 1'b1);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
